// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD FIFO controller.
// Holds the FSM encoding, the queued entry layout and the register map.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_WAIT
    } lcd_state_e;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_entry_t;

    localparam int ENTRY_W = 9;

    localparam logic [1:0] OFF_CMD     = 2'd0;
    localparam logic [1:0] OFF_DAT     = 2'd1;
    localparam logic [1:0] OFF_STATUS  = 2'd2;
    localparam logic [1:0] OFF_OVF_CLR = 2'd3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_FULL    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;

    // Clear (01) and home (02/03) need the long settle time.
    function automatic logic is_long_cmd(lcd_entry_t e);
        return !e.rs && (e.data == 8'h01 || e.data == 8'h02 ||
                         e.data == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Command/data FIFO feeding the LCD transfer FSM.
// Show-ahead read: rdata is the oldest entry whenever not empty.
module lcd_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = AW + 1
) (
    input  logic             ACLK,
    input  logic             RESET,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset since count guards reads.
    always_ff @(posedge ACLK) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; push+pop together leaves count unchanged.
    always_ff @(posedge ACLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_fifo_ctrl.sv
// Bus-mapped HD44780-style LCD controller with a command/data queue.
// Entries are replayed onto the LCD bus with timed EN pulses and settles.
import lcd_pkg::*;

module lcd_fifo_ctrl #(
    parameter logic [31:0] BASEADDRESS = 32'h5000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          EN_CYCLES   = 12,
    parameter int          SHORT_DELAY = 2000,
    parameter int          LONG_DELAY  = 100000,
    parameter int          NIBBLE_MODE = 0
) (
    input  logic        ACLK,
    input  logic        RESET,
    input  logic [31:0] DATA_I,
    input  logic [31:0] ADDR,
    input  logic        WRSTB,
    input  logic        RDSTB,
    output logic [31:0] DATA_O,
    output logic        LCD_BLON,
    output logic [7:0]  LCD_DATA,
    output logic        LCD_EN,
    output logic        LCD_ON,
    output logic        LCD_RS,
    output logic        LCD_RW
);

    localparam int MAX_DLY = (LONG_DELAY > EN_CYCLES) ? LONG_DELAY : EN_CYCLES;
    localparam int DW      = $clog2(MAX_DLY + 1);
    localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW      = AW + 1;

    lcd_state_e  state;
    logic [DW-1:0] cnt;
    lcd_entry_t  cur;
    logic        lo_nib;
    logic        overflow;

    logic [31:0] offset;
    logic        hit;
    logic        wr_q;
    logic        push;
    logic        pop;
    logic        ovf_set;
    logic        ovf_clr;
    logic        stat_rd;
    lcd_entry_t  push_entry;
    lcd_entry_t  head;
    logic        full;
    logic        empty;
    logic [CW-1:0] count;
    logic [31:0] status;
    logic        unused_data;

    assign LCD_BLON = 1'b1;
    assign LCD_ON   = 1'b1;
    assign LCD_RW   = 1'b0;

    assign unused_data = ^DATA_I[31:8];

    assign offset  = ADDR - BASEADDRESS;
    assign hit     = (offset[31:2] == 30'd0);
    assign wr_q    = WRSTB && hit &&
                     (offset[1:0] == OFF_CMD || offset[1:0] == OFF_DAT);
    assign push    = wr_q && !full;
    assign ovf_set = wr_q && full;
    assign ovf_clr = WRSTB && hit && (offset[1:0] == OFF_OVF_CLR);
    assign stat_rd = RDSTB && hit && (offset[1:0] == OFF_STATUS);
    assign pop     = (state == ST_IDLE) && !empty;

    assign push_entry.rs   = (offset[1:0] == OFF_DAT);
    assign push_entry.data = DATA_I[7:0];

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .ACLK  (ACLK),
        .RESET (RESET),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Bus value for one beat; nibble mode uses only the upper four lines.
    function automatic logic [7:0] bus_val(logic [7:0] d, logic lo);
        if (NIBBLE_MODE == 0) return d;
        return lo ? {d[3:0], 4'h0} : {d[7:4], 4'h0};
    endfunction

    // Status word assembly from live controller state.
    always_comb begin
        status = '0;
        status[STAT_BUSY]  = (state != ST_IDLE);
        status[STAT_EMPTY] = empty;
        status[STAT_FULL]  = full;
        status[STAT_OVF]   = overflow;
        status[STAT_CNT_LSB +: 8] = 8'(count);
    end

    // Registered read port; zero unless the status register was read.
    always_ff @(posedge ACLK) begin
        if (RESET) DATA_O <= '0;
        else       DATA_O <= stat_rd ? status : '0;
    end

    // Sticky overflow; a drop in the same cycle wins over a clear.
    always_ff @(posedge ACLK) begin
        if (RESET)        overflow <= 1'b0;
        else if (ovf_set) overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

    // Transfer FSM: setup, EN pulse, settle delay, per beat/entry.
    always_ff @(posedge ACLK) begin
        if (RESET) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cur      <= '0;
            lo_nib   <= 1'b0;
            LCD_EN   <= 1'b0;
            LCD_RS   <= 1'b0;
            LCD_DATA <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        state    <= ST_SETUP;
                        cur      <= head;
                        lo_nib   <= 1'b0;
                        cnt      <= DW'(1);
                        LCD_RS   <= head.rs;
                        LCD_DATA <= bus_val(head.data, 1'b0);
                    end
                end
                ST_SETUP: begin
                    state  <= ST_PULSE;
                    cnt    <= DW'(EN_CYCLES);
                    LCD_EN <= 1'b1;
                end
                ST_PULSE: begin
                    if (cnt <= DW'(1)) begin
                        LCD_EN <= 1'b0;
                        if (NIBBLE_MODE != 0 && !lo_nib) begin
                            state    <= ST_SETUP;
                            lo_nib   <= 1'b1;
                            cnt      <= DW'(1);
                            LCD_DATA <= bus_val(cur.data, 1'b1);
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= is_long_cmd(cur) ? DW'(LONG_DELAY)
                                                      : DW'(SHORT_DELAY);
                        end
                    end else begin
                        cnt <= cnt - DW'(1);
                    end
                end
                ST_WAIT: begin
                    if (cnt <= DW'(1)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - DW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_fifo_ctrl.sv
// Directed bench for lcd_fifo_ctrl: 8-bit and nibble instances.
// Expected LCD beats are queued at write time and matched on EN rise.
module tb_lcd_fifo_ctrl;

    localparam logic [31:0] BASE = 32'h5000_0000;
    localparam int EN = 4;
    localparam int SD = 20;
    localparam int LD = 60;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } exp_t;

    logic        aclk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_i = '0;
    logic [31:0] addr = '0;
    logic        wrstb8 = 1'b0, rdstb8 = 1'b0;
    logic        wrstb4 = 1'b0, rdstb4 = 1'b0;
    logic [31:0] data_o8, data_o4;
    logic        blon8, on8, rw8, en8, rs8;
    logic        blon4, on4, rw4, en4, rs4;
    logic [7:0]  d8, d4;

    exp_t q8[$];
    exp_t q4[$];
    int total = 0;
    int bad = 0;
    int rises8 = 0, done8 = 0, rises4 = 0, done4 = 0;
    bit abort = 1'b0;

    always #5 aclk = ~aclk;

    lcd_fifo_ctrl #(
        .BASEADDRESS (BASE), .FIFO_DEPTH (DEPTH), .EN_CYCLES (EN),
        .SHORT_DELAY (SD), .LONG_DELAY (LD), .NIBBLE_MODE (0)
    ) u8 (
        .ACLK (aclk), .RESET (reset), .DATA_I (data_i), .ADDR (addr),
        .WRSTB (wrstb8), .RDSTB (rdstb8), .DATA_O (data_o8),
        .LCD_BLON (blon8), .LCD_DATA (d8), .LCD_EN (en8),
        .LCD_ON (on8), .LCD_RS (rs8), .LCD_RW (rw8)
    );

    lcd_fifo_ctrl #(
        .BASEADDRESS (BASE), .FIFO_DEPTH (DEPTH), .EN_CYCLES (EN),
        .SHORT_DELAY (SD), .LONG_DELAY (LD), .NIBBLE_MODE (1)
    ) u4 (
        .ACLK (aclk), .RESET (reset), .DATA_I (data_i), .ADDR (addr),
        .WRSTB (wrstb4), .RDSTB (rdstb4), .DATA_O (data_o4),
        .LCD_BLON (blon4), .LCD_DATA (d4), .LCD_EN (en4),
        .LCD_ON (on4), .LCD_RS (rs4), .LCD_RW (rw4)
    );

    function automatic logic [31:0] stat(bit busy, bit empty, bit full,
                                         bit ovf, int cnt);
        return {16'h0, 8'(cnt), 4'h0, ovf, full, empty, busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard for the 8-bit instance.
    initial begin : mon8
        logic prev;
        int hi;
        exp_t e;
        prev = 1'b0;
        hi = 0;
        forever begin
            @(negedge aclk);
            if (en8 && !prev) begin
                rises8++;
                chk("pulse8_expected", 32'(q8.size() != 0), 32'd1);
                if (q8.size() != 0) begin
                    e = q8.pop_front();
                    chk("rs8", 32'(rs8), 32'(e.rs));
                    chk("data8", 32'(d8), 32'(e.data));
                end
                hi = 1;
            end else if (en8) begin
                hi++;
            end
            if (!en8 && prev) begin
                if (!abort) chk("en8_width", hi, EN);
                done8++;
            end
            prev = en8;
        end
    end

    // Scoreboard for the nibble instance.
    initial begin : mon4
        logic prev;
        int hi;
        exp_t e;
        prev = 1'b0;
        hi = 0;
        forever begin
            @(negedge aclk);
            if (en4 && !prev) begin
                rises4++;
                chk("pulse4_expected", 32'(q4.size() != 0), 32'd1);
                if (q4.size() != 0) begin
                    e = q4.pop_front();
                    chk("rs4", 32'(rs4), 32'(e.rs));
                    chk("data4", 32'(d4), 32'(e.data));
                end
                hi = 1;
            end else if (en4) begin
                hi++;
            end
            if (!en4 && prev) begin
                if (!abort) chk("en4_width", hi, EN);
                done4++;
            end
            prev = en4;
        end
    end

    task automatic wr(input bit sel, input logic [31:0] a,
                      input logic [7:0] d);
        addr = a;
        data_i = {24'hA5A5A5, d};
        if (sel) wrstb4 = 1'b1;
        else     wrstb8 = 1'b1;
        @(negedge aclk);
        wrstb4 = 1'b0;
        wrstb8 = 1'b0;
    endtask

    task automatic rd(input bit sel, output logic [31:0] v);
        addr = BASE + 32'd2;
        if (sel) rdstb4 = 1'b1;
        else     rdstb8 = 1'b1;
        @(negedge aclk);
        rdstb4 = 1'b0;
        rdstb8 = 1'b0;
        v = sel ? data_o4 : data_o8;
    endtask

    task automatic wait_done(input bit sel, input int tgt, input string tag);
        int n;
        n = 0;
        while ((sel ? done4 : done8) < tgt && n < 3000) begin
            @(negedge aclk);
            #1;
            n++;
        end
        chk(tag, 32'((sel ? done4 : done8) >= tgt), 32'd1);
    endtask

    task automatic wait_rise(input bit sel, input int tgt, input string tag);
        int n;
        n = 0;
        while ((sel ? rises4 : rises8) < tgt && n < 3000) begin
            @(negedge aclk);
            #1;
            n++;
        end
        chk(tag, 32'((sel ? rises4 : rises8) >= tgt), 32'd1);
    endtask

    task automatic busy_len(input bit sel, output int n);
        logic [31:0] v;
        n = 0;
        for (int k = 0; k < 500; k++) begin
            rd(sel, v);
            if (!v[0]) break;
            n++;
        end
    endtask

    task automatic xfer8(input bit rs, input logic [7:0] d,
                         input int dly, input string tag);
        int t;
        int n;
        q8.push_back('{rs, d});
        t = done8 + 1;
        wr(1'b0, BASE + (rs ? 32'd1 : 32'd0), d);
        wait_done(1'b0, t, {tag, "_timeout"});
        busy_len(1'b0, n);
        chk(tag, n, dly);
    endtask

    initial begin : main
        logic [31:0] v;
        int t;
        int n;
        int r;

        reset = 1'b1;
        repeat (3) @(negedge aclk);
        chk("rst_en", 32'(en8), 32'd0);
        chk("rst_rs", 32'(rs8), 32'd0);
        chk("rst_data", 32'(d8), 32'd0);
        chk("rst_data_o", data_o8, 32'd0);
        chk("const_lines8", {29'd0, blon8, on8, rw8}, 32'd6);
        chk("const_lines4", {29'd0, blon4, on4, rw4}, 32'd6);
        reset = 1'b0;
        rd(1'b0, v);
        chk("status_reset8", v, stat(0, 1, 0, 0, 0));
        rd(1'b1, v);
        chk("status_reset4", v, stat(0, 1, 0, 0, 0));
        @(negedge aclk);
        chk("data_o_no_read", data_o8, 32'd0);

        // Basic command with exact EN latency.
        q8.push_back('{1'b0, 8'h38});
        t = done8 + 1;
        wr(1'b0, BASE, 8'h38);
        chk("lat_after_write", 32'(en8), 32'd0);
        @(negedge aclk);
        chk("lat_setup_en", 32'(en8), 32'd0);
        chk("setup_data", 32'(d8), 32'h38);
        chk("setup_rs", 32'(rs8), 32'd0);
        @(negedge aclk);
        chk("lat_pulse_en", 32'(en8), 32'd1);
        wait_done(1'b0, t, "cmd38_timeout");
        busy_len(1'b0, n);
        chk("cmd38_wait", n, SD);
        rd(1'b0, v);
        chk("cmd38_idle", v, stat(0, 1, 0, 0, 0));

        // Delay selection.
        xfer8(1'b0, 8'h01, LD, "clear_wait");
        xfer8(1'b0, 8'h03, LD, "home3_wait");
        xfer8(1'b0, 8'h04, SD, "cmd04_wait");
        xfer8(1'b1, 8'h01, SD, "data01_wait");

        // Writes outside the window are ignored.
        r = rises8;
        wr(1'b0, BASE + 32'd4, 8'h11);
        wr(1'b0, BASE - 32'd1, 8'h12);
        wr(1'b0, 32'h0, 8'h13);
        repeat (5) @(negedge aclk);
        chk("oor_no_pulse", rises8, r);
        rd(1'b0, v);
        chk("oor_status", v, stat(0, 1, 0, 0, 0));

        // Nibble mode: two beats, high then low.
        q4.push_back('{1'b1, 8'h40});
        q4.push_back('{1'b1, 8'h10});
        t = done4 + 2;
        wr(1'b1, BASE + 32'd1, 8'h41);
        wait_done(1'b1, t, "nib_timeout");
        busy_len(1'b1, n);
        chk("nib_wait", n, SD);
        chk("nib_beats", rises4, 2);

        // Overflow: nine writes while a transfer is in flight.
        q8.push_back('{1'b0, 8'h05});
        t = done8 + 9;
        wait_rise(1'b0, rises8 + 0, "ovf_dummy");
        r = rises8 + 1;
        wr(1'b0, BASE, 8'h05);
        wait_rise(1'b0, r, "ovf_rise_timeout");
        for (int i = 0; i < 9; i++) begin
            logic [7:0] dd;
            dd = 8'h20 + 8'(i);
            if (i < 8) q8.push_back('{1'(i % 2), dd});
            wr(1'b0, BASE + 32'(i % 2), dd);
        end
        rd(1'b0, v);
        chk("ovf_status", v, stat(1, 0, 1, 1, 8));
        wr(1'b0, BASE + 32'd3, 8'h00);
        rd(1'b0, v);
        chk("ovf_cleared", v, stat(1, 0, 1, 0, 8));
        wait_done(1'b0, t, "ovf_drain_timeout");
        busy_len(1'b0, n);
        rd(1'b0, v);
        chk("ovf_drained", v, stat(0, 1, 0, 0, 0));

        // Push coinciding with pop at count 3.
        q8.push_back('{1'b1, 8'h50});
        t = done8 + 1;
        wr(1'b0, BASE + 32'd1, 8'h50);
        wait_done(1'b0, t, "pp_first_timeout");
        q8.push_back('{1'b1, 8'h51});
        q8.push_back('{1'b1, 8'h52});
        q8.push_back('{1'b0, 8'h53});
        wr(1'b0, BASE + 32'd1, 8'h51);
        wr(1'b0, BASE + 32'd1, 8'h52);
        wr(1'b0, BASE, 8'h53);
        repeat (SD - 3) @(negedge aclk);
        q8.push_back('{1'b1, 8'h54});
        wr(1'b0, BASE + 32'd1, 8'h54);
        rd(1'b0, v);
        chk("pushpop_count", v, stat(1, 0, 0, 0, 3));
        wait_done(1'b0, t + 4, "pp_drain_timeout");
        busy_len(1'b0, n);
        rd(1'b0, v);
        chk("pp_drained", v, stat(0, 1, 0, 0, 0));

        // Reset during the third queued pulse.
        q8.push_back('{1'b1, 8'h60});
        q8.push_back('{1'b1, 8'h61});
        q8.push_back('{1'b1, 8'h62});
        r = rises8;
        wr(1'b0, BASE + 32'd1, 8'h60);
        wr(1'b0, BASE + 32'd1, 8'h61);
        wr(1'b0, BASE + 32'd1, 8'h62);
        wait_rise(1'b0, r + 3, "rst3_timeout");
        abort = 1'b1;
        reset = 1'b1;
        @(negedge aclk);
        chk("abort_en", 32'(en8), 32'd0);
        chk("abort_rs", 32'(rs8), 32'd0);
        chk("abort_data", 32'(d8), 32'd0);
        reset = 1'b0;
        rd(1'b0, v);
        chk("abort_status", v, 32'h2);
        r = rises8;
        repeat (200) @(negedge aclk);
        chk("abort_no_pulse", rises8, r);
        abort = 1'b0;

        chk("q8_drained", q8.size(), 0);
        chk("q4_drained", q4.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
